// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic             br_q;
    logic             br_d;
    logic             d_s;
    logic             last_s;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             amsb_q;
    logic             bmsb_q;
    logic             ovf_q;
    logic             ovf_d;
`endif

    // Returns {borrow_out, difference} of one full-subtractor cell.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        full_sub = {(~x & y) | (~x & bi) | (y & bi), x ^ y ^ bi};
    endfunction

    // Single-bit datapath: current cell result and next shift-register contents.
    always_comb begin
        {br_d, d_s} = full_sub(a_q[0], b_q[0], br_q);
        sh_d        = (sh_q >> 1) | (WIDTH'(d_s) << (WIDTH - 1));
        last_s      = (cnt_q == CW'(WIDTH - 1));
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d       = (amsb_q != bmsb_q) && (d_s != amsb_q);
`endif
    end

    // Control FSM with operand/result registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        amsb_q  <= a[WIDTH-1];
                        bmsb_q  <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Results become visible only on the edge that finishes the last bit.
                    if (last_s) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= sh_d;
                        bout_q  <= br_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_q   <= ovf_d;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Inverse-direction companion to the parallel adder datapath; used where area matters more than latency.
- Start/busy/done handshake lets a controller launch an operation and collect the result.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset: asynchronous, active-low.
  - The state machine goes to IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge, capture a, b and bin. The borrow flop loads bin.
  - Clear the bit counter and go to RUN.
  - If start=0, stay in IDLE.
- RUN (busy=1): each edge processes the current LSB of the a and b shift registers.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~a0 & br) | (b0 & br).
  - Shift a and b right by one. Shift d into the MSB of the diff shift register.
  - Increment the counter. On the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - diff and bout hold their values until the next accepted start completes.
- Latency: start accepted at edge k -> RUN during edges k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles.
- start in RUN or DONE: ignored. No queuing. Captured operands are unaffected.
- Changes on a, b or bin after capture: no effect on the operation in flight.
- diff and bout outputs:
  - Update only on the edge that enters DONE. Intermediate shift contents are not visible.
  - bout equals the final borrow flop value.
- Counter width is $clog2(WIDTH)+1. WIDTH=1 is legal: one RUN cycle.
- Reset asserted mid-operation: the operation is aborted immediately, all outputs return to reset values, and there is no done pulse.
- start held high continuously: a new operation is accepted in each IDLE cycle, one every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0).
  - Updated together with diff on entry to DONE.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operands, i.e. signed two's-complement overflow of a - b - bin.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- WIDTH=4: a=9, b=3, bin=0, pulse start -> done after 5 cycles; diff=6, bout=0; busy high exactly 4 cycles.
- WIDTH=4: a=3, b=9, bin=0 -> diff=4'hA, bout=1. Then a=5, b=5, bin=1 -> diff=4'hF, bout=1.
- Start pulsed again in the 2nd RUN cycle with a=15, b=0 -> ignored; the original result is unchanged and only one done pulse occurs.
- rst_n dropped in the 3rd RUN cycle -> busy, done, diff, bout immediately 0. After release, a fresh start (a=7, b=2) -> diff=5.
- WIDTH=8: a=200, b=55 -> diff=145, bout=0. a=0, b=1, bin=1 -> diff=254, bout=1. start held high -> done every 10 cycles.
- SERIAL_SUB_OVERFLOW_EN, WIDTH=4:
  - a=4'b0111, b=4'b1111 -> diff=4'b1000, ovf=1, bout=1.
  - a=4'b0011, b=4'b0001 -> ovf=0.
